ship_motion_controller: RTL and testbench

- Parametrised successor to the single-speed ship mover.
- Drives the player ship's top-left x coordinate on one master clock. Movement is paced by an internal tick divider instead of a derived clock.
- Adds hold-to-accelerate speed ramping, optional edge wrap-around, an at-edge flag, and a rate-limited fire pulse.
- Sits between the debounced button inputs and the game controller, which handles drawing.

---
 rtl/ship_motion_controller_if.sv | 25 ++
 rtl/ship_motion_controller.sv | 145 ++++++++++++++
 tb/tb_ship_motion_controller.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ship_motion_controller_if.sv
// Button-request and ship-state bundle between the debounced inputs, the
// ship motion controller and the game controller.
interface ship_motion_controller_if #(
    parameter int POS_W = 10
);
    logic             d_right;
    logic             d_left;
    logic             d_fire;
    logic [POS_W-1:0] ship_x;
    logic [3:0]       speed;
    logic             moving;
    logic             at_edge;
    logic             fire_pulse;
    logic             tick;

    modport master (
        input  d_right, d_left, d_fire,
        output ship_x, speed, moving, at_edge, fire_pulse, tick
    );

    modport slave (
        output d_right, d_left, d_fire,
        input  ship_x, speed, moving, at_edge, fire_pulse, tick
    );
endinterface

// File: rtl/ship_motion_controller.sv
// Player ship mover: tick-paced horizontal motion with hold-to-accelerate,
// edge clamp or wrap, and a cooldown-limited fire pulse.
module ship_motion_controller #(
    parameter int POS_W         = 10,
    parameter int LEFT_BOUND    = 144,
    parameter int RIGHT_BOUND   = 584,
    parameter int SPRITE_W      = 24,
    parameter int TICK_DIV      = 250000,
    parameter int MAX_SPEED     = 4,
    parameter int ACCEL_TICKS   = 8,
    parameter int FIRE_COOLDOWN = 30,
    parameter int WRAP          = 0
) (
    input  logic                      clk_master,
    input  logic                      d_reset,
    ship_motion_controller_if.master  bus
);
    localparam int PW     = POS_W + 1;
    localparam int MAX_X  = RIGHT_BOUND - SPRITE_W;
    localparam int CENTER = (LEFT_BOUND + RIGHT_BOUND - SPRITE_W) / 2;
    localparam int TW     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int HW     = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
    localparam int CW     = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;

    localparam logic [PW-1:0]    LEFT_P   = PW'(LEFT_BOUND);
    localparam logic [PW-1:0]    MAX_P    = PW'(MAX_X);
    localparam logic [POS_W-1:0] LEFT_X   = POS_W'(LEFT_BOUND);
    localparam logic [POS_W-1:0] MAX_XV   = POS_W'(MAX_X);
    localparam logic [POS_W-1:0] CENTER_X = POS_W'(CENTER);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MOVE_R = 2'd1;
    localparam logic [1:0] MOVE_L = 2'd2;

    logic [TW-1:0]    tick_cnt;
    logic             tick_r;
    logic [1:0]       state;
    logic [1:0]       state_n;
    logic [1:0]       want;
    logic [3:0]       speed_r;
    logic [3:0]       speed_n;
    logic [HW-1:0]    hold;
    logic [HW-1:0]    hold_n;
    logic [CW-1:0]    cooldown;
    logic [POS_W-1:0] x_r;
    logic [POS_W-1:0] x_n;
    logic             fire_r;

    // Sums are formed one bit wider so a step past the top of the bus
    // still compares correctly against the edge.
    function automatic logic [POS_W-1:0] step_right(input logic [POS_W-1:0] x,
                                                    input logic [3:0] s);
        logic [PW-1:0] sum;
        sum = {1'b0, x} + PW'(s);
        if (WRAP != 0 && x == MAX_XV)
            return LEFT_X;
        else if (sum > MAX_P)
            return MAX_XV;
        return sum[POS_W-1:0];
    endfunction

    function automatic logic [POS_W-1:0] step_left(input logic [POS_W-1:0] x,
                                                   input logic [3:0] s);
        logic [PW-1:0] lim;
        logic [PW-1:0] dif;
        lim = LEFT_P + PW'(s);
        dif = {1'b0, x} - PW'(s);
        if (WRAP != 0 && x == LEFT_X)
            return MAX_XV;
        else if ({1'b0, x} < lim)
            return LEFT_X;
        return dif[POS_W-1:0];
    endfunction

    always_comb begin
        want    = IDLE;
        state_n = state;
        speed_n = speed_r;
        hold_n  = hold;
        x_n     = x_r;
        if (bus.d_right && !bus.d_left)
            want = MOVE_R;
        else if (bus.d_left && !bus.d_right)
            want = MOVE_L;

        if (want == IDLE) begin
            state_n = IDLE;
            speed_n = 4'd0;
            hold_n  = '0;
        end else if (want != state) begin
            state_n = want;
            speed_n = 4'd1;
            hold_n  = '0;
        end else if (hold == HW'(ACCEL_TICKS - 1)) begin
            hold_n = '0;
            if (speed_r < 4'(MAX_SPEED))
                speed_n = speed_r + 4'd1;
        end else begin
            hold_n = hold + HW'(1);
        end

        // The step taken this tick is the speed the ship leaves the tick with.
        if (state_n == MOVE_R)
            x_n = step_right(x_r, speed_n);
        else if (state_n == MOVE_L)
            x_n = step_left(x_r, speed_n);
    end

    always_ff @(posedge clk_master) begin
        if (d_reset) begin
            tick_cnt <= '0;
            tick_r   <= 1'b0;
            state    <= IDLE;
            speed_r  <= 4'd0;
            hold     <= '0;
            cooldown <= '0;
            x_r      <= CENTER_X;
            fire_r   <= 1'b0;
        end else begin
            tick_cnt <= (tick_cnt == TW'(TICK_DIV - 1)) ? '0 : tick_cnt + TW'(1);
            // Registered strobe lands in the cycle where the counter reads TICK_DIV-1.
            tick_r   <= (tick_cnt == TW'(TICK_DIV - 2));
            fire_r   <= 1'b0;
            if (tick_r) begin
                state   <= state_n;
                speed_r <= speed_n;
                hold    <= hold_n;
                x_r     <= x_n;
                if (bus.d_fire && cooldown == '0) begin
                    fire_r   <= 1'b1;
                    cooldown <= CW'(FIRE_COOLDOWN);
                end else if (cooldown != '0) begin
                    cooldown <= cooldown - CW'(1);
                end
            end
        end
    end

    assign bus.ship_x     = x_r;
    assign bus.speed      = speed_r;
    assign bus.moving     = (state != IDLE);
    assign bus.at_edge    = (x_r == LEFT_X) || (x_r == MAX_XV);
    assign bus.fire_pulse = fire_r;
    assign bus.tick       = tick_r;
endmodule

// File: tb/tb_ship_motion_controller.sv
// Directed bench for ship_motion_controller: a clamping and a wrapping
// instance driven by the same buttons, checked once per movement tick.
module tb_ship_motion_controller;
    logic clk = 1'b0;
    logic rst;
    logic r, l, f;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ship_motion_controller_if #(.POS_W(10)) ia ();
    ship_motion_controller_if #(.POS_W(10)) ib ();

    assign ia.d_right = r;
    assign ia.d_left  = l;
    assign ia.d_fire  = f;
    assign ib.d_right = r;
    assign ib.d_left  = l;
    assign ib.d_fire  = f;

    ship_motion_controller #(
        .TICK_DIV(4), .MAX_SPEED(3), .ACCEL_TICKS(2), .FIRE_COOLDOWN(3), .WRAP(0)
    ) u_clamp (
        .clk_master(clk), .d_reset(rst), .bus(ia)
    );

    ship_motion_controller #(
        .TICK_DIV(4), .MAX_SPEED(3), .ACCEL_TICKS(2), .FIRE_COOLDOWN(3), .WRAP(1)
    ) u_wrap (
        .clk_master(clk), .d_reset(rst), .bus(ib)
    );

    typedef struct {
        logic       r;
        logic       l;
        logic       f;
        logic [9:0] x;
        logic [3:0] spd;
        logic       mov;
        logic       at_e;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Hold the buttons through the next tick cycle, then stop on the
    // falling edge right after it, where the tick's results are visible.
    task automatic step(input logic rr, input logic ll, input logic ff);
        int n;
        r = rr;
        l = ll;
        f = ff;
        n = 0;
        while (ia.tick !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (ia.tick !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL tick_timeout: got no tick, expected one within 10 cycles");
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        //           r     l     f     x        spd   mov   edge
        tbl[0] = '{1'b1, 1'b0, 1'b0, 10'd353, 4'd1, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 10'd354, 4'd1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 10'd356, 4'd2, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 10'd358, 4'd2, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 10'd361, 4'd3, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 10'd364, 4'd3, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 10'd367, 4'd3, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 10'd366, 4'd1, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 10'd367, 4'd1, 1'b1, 1'b0};

        rst = 1'b1;
        r = 1'b0;
        l = 1'b0;
        f = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset ship_x", ia.ship_x, 352);
        chk("reset speed", ia.speed, 0);
        chk("reset moving", ia.moving, 0);
        chk("reset at_edge", ia.at_edge, 0);
        chk("reset fire_pulse", ia.fire_pulse, 0);
        chk("reset tick", ia.tick, 0);
        chk("reset wrap ship_x", ib.ship_x, 352);

        // The 4th cycle after the last reset edge is the first tick, then every 4th.
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk($sformatf("tick cycle %0d", i), ia.tick, (i == 3 || i == 7) ? 1 : 0);
        end

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].r, tbl[i].l, tbl[i].f);
            chk($sformatf("row%0d ship_x", i), ia.ship_x, tbl[i].x);
            chk($sformatf("row%0d speed", i), ia.speed, tbl[i].spd);
            chk($sformatf("row%0d moving", i), ia.moving, tbl[i].mov);
            chk($sformatf("row%0d at_edge", i), ia.at_edge, tbl[i].at_e);
            chk($sformatf("row%0d wrap ship_x", i), ib.ship_x, tbl[i].x);
        end

        // Restarted right from 366: x = 360 + 3k once at top speed.
        for (int k = 2; k <= 66; k++) step(1'b1, 1'b0, 1'b0);
        chk("approach ship_x", ia.ship_x, 558);
        chk("approach speed", ia.speed, 3);
        chk("approach wrap ship_x", ib.ship_x, 558);

        step(1'b1, 1'b0, 1'b0);
        chk("right clamp ship_x", ia.ship_x, 560);
        chk("right clamp at_edge", ia.at_edge, 1);
        chk("right land wrap ship_x", ib.ship_x, 560);
        chk("right land wrap at_edge", ib.at_edge, 1);

        step(1'b1, 1'b0, 1'b0);
        chk("right hold ship_x", ia.ship_x, 560);
        chk("right hold speed", ia.speed, 3);
        chk("right wrap ship_x", ib.ship_x, 144);

        step(1'b0, 1'b1, 1'b0);
        chk("reverse ship_x", ia.ship_x, 559);
        chk("reverse speed", ia.speed, 1);
        chk("reverse at_edge", ia.at_edge, 0);
        chk("left wrap ship_x", ib.ship_x, 560);

        step(1'b1, 1'b1, 1'b0);
        chk("both ship_x", ia.ship_x, 559);
        chk("both speed", ia.speed, 0);
        chk("both moving", ia.moving, 0);
        chk("both wrap moving", ib.moving, 0);

        // From 559 (clamp) and 560 (wrap) heading left: x0 + 6 - 3k at top speed.
        for (int k = 1; k <= 140; k++) step(1'b0, 1'b1, 1'b0);
        chk("left approach ship_x", ia.ship_x, 145);
        chk("left approach speed", ia.speed, 3);
        chk("left approach wrap ship_x", ib.ship_x, 146);

        step(1'b0, 1'b1, 1'b0);
        chk("left clamp ship_x", ia.ship_x, 144);
        chk("left clamp at_edge", ia.at_edge, 1);
        chk("left land wrap ship_x", ib.ship_x, 144);

        step(1'b0, 1'b1, 1'b0);
        chk("left hold ship_x", ia.ship_x, 144);
        chk("left wrap again ship_x", ib.ship_x, 560);

        for (int t = 1; t <= 10; t++) begin
            step(1'b0, 1'b0, 1'b1);
            chk($sformatf("fire tick %0d", t), ia.fire_pulse, (t % 4 == 1) ? 1 : 0);
            @(negedge clk);
            chk($sformatf("fire tick %0d width", t), ia.fire_pulse, 0);
        end

        // Cooldown is at 2 here; a reset must clear it so the next tick fires.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid reset ship_x", ia.ship_x, 352);
        chk("mid reset fire_pulse", ia.fire_pulse, 0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        chk("fire after reset", ia.fire_pulse, 1);
        step(1'b0, 1'b0, 1'b1);
        chk("cooldown after reset fire", ia.fire_pulse, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
